alu_mul_sequencer: RTL and testbench



---
 rtl/alu_mul_sequencer_pkg.sv | 15 +
 rtl/alu_mul_sequencer_alu.sv | 36 +++
 rtl/alu_mul_sequencer.sv | 125 ++++++++++++
 tb/tb_alu_mul_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_mul_sequencer_pkg.sv
// ALU opcode codes shared by the EX-stage ALU and the multiply sequencer.
// Codes are 4 bits; consumers cast them to their own control width.
package alu_mul_sequencer_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_XOR = 4'b1101;

endpackage

// File: rtl/alu_mul_sequencer_alu.sv
// EX-stage ALU, purely combinational (zero latency, no flow control).
// Undefined control codes fall back to ADD.
module alu_mul_sequencer_alu
  import alu_mul_sequencer_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ALU_CTRL_W = 4
) (
  input  logic [WIDTH-1:0]      a_i,
  input  logic [WIDTH-1:0]      b_i,
  input  logic [ALU_CTRL_W-1:0] ctrl_i,
  output logic [WIDTH-1:0]      result_o
);

  localparam int SHW = $clog2(WIDTH);

  always_comb begin
    result_o = a_i + b_i;
    case (ctrl_i)
      ALU_CTRL_W'(ALU_AND): result_o = a_i & b_i;
      ALU_CTRL_W'(ALU_OR):  result_o = a_i | b_i;
      ALU_CTRL_W'(ALU_ADD): result_o = a_i + b_i;
      ALU_CTRL_W'(ALU_SUB): result_o = a_i - b_i;
      ALU_CTRL_W'(ALU_SLT): begin
        result_o    = '0;
        result_o[0] = $signed(a_i) < $signed(b_i);
      end
      ALU_CTRL_W'(ALU_SLL): result_o = a_i << b_i[SHW-1:0];
      ALU_CTRL_W'(ALU_SRL): result_o = a_i >> b_i[SHW-1:0];
      ALU_CTRL_W'(ALU_NOR): result_o = ~(a_i | b_i);
      ALU_CTRL_W'(ALU_XOR): result_o = a_i ^ b_i;
      default:              result_o = a_i + b_i;
    endcase
  end

endmodule

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add MUL (low WIDTH bits) driven through the EX ALU; 2(k+1)+2 cycles, k = top set bit of op_b.
// Pipeline stalls on busy; start is only taken in IDLE/DONE, flush aborts to IDLE.
module alu_mul_sequencer
  import alu_mul_sequencer_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ALU_CTRL_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  flush,
  input  logic [WIDTH-1:0]      op_a,
  input  logic [WIDTH-1:0]      op_b,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH-1:0]      product,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  output logic [ALU_CTRL_W-1:0] alu_control,
  input  logic [WIDTH-1:0]      alu_result
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADD   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] product_q, product_d;
  logic             busy_q, done_q;
  logic             accept;

  assign accept = start && !flush && (state_q == S_IDLE || state_q == S_DONE);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    product_d = product_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          acc_d    = '0;
          mcand_d  = op_a;
          mplier_d = op_b;
          state_d  = S_ADD;
        end
      end
      S_ADD: begin
        if (mplier_q == '0) begin
          product_d = acc_q;
          state_d   = S_DONE;
        end else begin
          if (mplier_q[0]) acc_d = alu_result;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        mcand_d  = alu_result;
        mplier_d = mplier_q >> 1;
        state_d  = S_ADD;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort wins over both a new start and completion; datapath is frozen.
    if (flush) begin
      state_d   = S_IDLE;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      product_d = product_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      product_q <= product_d;
      busy_q    <= (state_d == S_ADD) || (state_d == S_SHIFT);
      done_q    <= (state_d == S_DONE);
    end
  end

  always_comb begin
    alu_a       = '0;
    alu_b       = '0;
    alu_control = ALU_CTRL_W'(ALU_ADD);
    case (state_q)
      S_ADD: begin
        alu_a = acc_q;
        alu_b = mcand_q;
      end
      S_SHIFT: begin
        alu_a       = mcand_q;
        alu_b       = WIDTH'(1);
        alu_control = ALU_CTRL_W'(ALU_SLL);
      end
      default: ;
    endcase
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer paired with the EX ALU: directed table, corner sequences, random vs. model.
module tb_alu_mul_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [31:0] op_a, op_b;
  logic        busy, done;
  logic [31:0] product, alu_a, alu_b, alu_result;
  logic [3:0]  alu_control;

  int total  = 0;
  int passed = 0;
  logic [31:0] last_prod;

  always #5 clk = ~clk;

  alu_mul_sequencer #(.WIDTH(32), .ALU_CTRL_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .flush(flush),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .product(product),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .alu_result(alu_result)
  );

  alu_mul_sequencer_alu #(.WIDTH(32), .ALU_CTRL_W(4)) u_alu (
    .a_i(alu_a), .b_i(alu_b), .ctrl_i(alu_control), .result_o(alu_result)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_prod;
    int          exp_lat;
  } vec_t;

  vec_t vecs[5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] model_prod(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    return p[31:0];
  endfunction

  function automatic int model_lat(input logic [31:0] b);
    int k = -1;
    for (int i = 0; i < 32; i++) if (b[i]) k = i;
    return 2 * (k + 1) + 2;
  endfunction

  // Steps until done is seen; ok drops if busy is low before done or high with done.
  task automatic wait_done(input int c0, output int cyc, output bit seen, output bit ok);
    seen = 0;
    ok   = 1;
    cyc  = c0;
    while (!seen && cyc <= 80) begin
      if (done) begin
        seen = 1;
        if (busy) ok = 0;
      end else begin
        if (!busy) ok = 0;
        step();
        cyc++;
      end
    end
  endtask

  task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_p, input int exp_lat, input string name);
    int cyc;
    bit seen, ok;
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(1, cyc, seen, ok);
    chk({name, "_done_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      chk({name, "_latency"}, 64'(cyc), 64'(exp_lat));
      chk({name, "_product"}, 64'(product), 64'(exp_p));
    end
    chk({name, "_busy_window"}, 64'(ok), 64'd1);
    step();
    chk({name, "_done_pulse_end"}, 64'({busy, done}), 64'd0);
    last_prod = exp_p;
  endtask

  initial begin
    int cyc;
    bit seen, ok, any_done;
    logic [31:0] ra, rb;

    vecs[0] = '{32'd7,        32'd6,          32'd42,         8};
    vecs[1] = '{32'hFFFFFFFF, 32'd3,          32'hFFFFFFFD,   6};
    vecs[2] = '{32'h12345678, 32'd0,          32'd0,          2};
    vecs[3] = '{32'h00010000, 32'h80000000,   32'd0,          66};
    vecs[4] = '{32'd1,        32'd1,          32'd1,          4};

    reset = 1'b1; start = 1'b0; flush = 1'b0; op_a = '0; op_b = '0;
    last_prod = '0;
    step();
    step();
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_product", 64'(product), 64'd0);
    chk("reset_alu_ops", 64'({alu_a, alu_b}), 64'd0);
    chk("reset_alu_ctrl", 64'(alu_control), 64'd2);
    reset = 1'b0;
    step();

    foreach (vecs[i]) run_mul(vecs[i].a, vecs[i].b, vecs[i].exp_prod, vecs[i].exp_lat, $sformatf("vec%0d", i));

    // Flush mid-multiply: no done, product retained, then a clean restart.
    op_a = 32'd5; op_b = 32'd5; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_idle_busy", 64'(busy), 64'd0);
    chk("flush_no_done", 64'(done), 64'd0);
    chk("flush_product_held", 64'(product), 64'(last_prod));
    any_done = 0;
    for (int i = 0; i < 8; i++) begin
      if (done || busy) any_done = 1;
      step();
    end
    chk("flush_stays_idle", 64'(any_done), 64'd0);
    run_mul(32'd3, 32'd4, 32'd12, 8, "after_flush");

    // Flush in the completing ADD cycle suppresses done and the product update.
    op_a = 32'd5; op_b = 32'd0; start = 1'b1;
    step();
    start = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_vs_done_done", 64'(done), 64'd0);
    chk("flush_vs_done_product", 64'(product), 64'd12);

    // Flush beats a simultaneous start.
    op_a = 32'd1; op_b = 32'd1; start = 1'b1; flush = 1'b1;
    step();
    start = 1'b0; flush = 1'b0;
    chk("flush_vs_start_busy", 64'(busy), 64'd0);
    step();

    // Back-to-back: start held, second operands captured in the DONE cycle.
    op_a = 32'd2; op_b = 32'd2; start = 1'b1;
    step();
    op_a = 32'd9; op_b = 32'd1;
    wait_done(1, cyc, seen, ok);
    chk("b2b_first_seen", 64'(seen), 64'd1);
    chk("b2b_first_latency", 64'(cyc), 64'd6);
    chk("b2b_first_product", 64'(product), 64'd4);
    chk("b2b_first_busy", 64'(ok), 64'd1);
    step();
    start = 1'b0;
    chk("b2b_reaccept_busy", 64'(busy), 64'd1);
    wait_done(1, cyc, seen, ok);
    chk("b2b_second_seen", 64'(seen), 64'd1);
    chk("b2b_second_latency", 64'(cyc), 64'd4);
    chk("b2b_second_product", 64'(product), 64'd9);
    step();

    // ALU drive in ADD/SHIFT, then reset mid-operation.
    op_a = 32'd7; op_b = 32'd6; start = 1'b1;
    step();
    start = 1'b0;
    chk("add_alu_a", 64'(alu_a), 64'd0);
    chk("add_alu_b", 64'(alu_b), 64'd7);
    chk("add_alu_ctrl", 64'(alu_control), 64'd2);
    step();
    chk("shift_alu_a", 64'(alu_a), 64'd7);
    chk("shift_alu_b", 64'(alu_b), 64'd1);
    chk("shift_alu_ctrl", 64'(alu_control), 64'd8);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midreset_busy_done", 64'({busy, done}), 64'd0);
    chk("midreset_product", 64'(product), 64'd0);
    chk("midreset_alu_ops", 64'({alu_a, alu_b}), 64'd0);
    chk("midreset_alu_ctrl", 64'(alu_control), 64'd2);
    step();
    run_mul(32'd7, 32'd6, 32'd42, 8, "after_reset");

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      run_mul(ra, rb, model_prod(ra, rb), model_lat(rb), $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
